// File: rtl/camera_download_reader.sv
// rtl/camera_download_reader.sv - drains a camera frame buffer to the host over a valid/ack handshake
module camera_download_reader #(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ready_to_download,
  input  logic [3:0]        fill_level,
  output logic [3:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [3:0]        drained_count
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PRESENT, DONE} state_t;

  state_t            state, state_n;
  logic              rdy_q, rdy_q_n;
  logic [3:0]        count, count_n;
  logic [3:0]        idx, idx_n;
  logic [3:0]        rd_addr_n;
  logic [DATA_W-1:0] byte_out_n;
  logic              byte_valid_n, busy_n, done_n, aborted_n;
  logic [3:0]        drained_n;
  logic              in_xfer;

  assign in_xfer = (state == ADDR) || (state == WAIT) || (state == PRESENT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      rdy_q         <= 1'b1;
      count         <= '0;
      idx           <= '0;
      rd_addr       <= '0;
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      drained_count <= '0;
    end else begin
      state         <= state_n;
      rdy_q         <= rdy_q_n;
      count         <= count_n;
      idx           <= idx_n;
      rd_addr       <= rd_addr_n;
      byte_out      <= byte_out_n;
      byte_valid    <= byte_valid_n;
      busy          <= busy_n;
      done          <= done_n;
      aborted       <= aborted_n;
      drained_count <= drained_n;
    end
  end

  always_comb begin
    state_n      = state;
    rdy_q_n      = ready_to_download;
    count_n      = count;
    idx_n        = idx;
    rd_addr_n    = rd_addr;
    byte_out_n   = byte_out;
    byte_valid_n = byte_valid;
    busy_n       = busy;
    done_n       = 1'b0;
    aborted_n    = 1'b0;
    drained_n    = drained_count;

    // Losing ready mid-transfer cancels outright, even if the host acks that same cycle.
    if (in_xfer && !ready_to_download) begin
      state_n      = IDLE;
      byte_valid_n = 1'b0;
      busy_n       = 1'b0;
      aborted_n    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy_n = 1'b0;
          if (ready_to_download && !rdy_q) begin
            count_n   = (fill_level > DEPTH_L) ? DEPTH_L : fill_level;
            idx_n     = '0;
            drained_n = '0;
            rd_addr_n = '0;
            busy_n    = 1'b1;
            state_n   = (count_n == 4'd0) ? DONE : ADDR;
          end
        end
        ADDR: state_n = WAIT;
        WAIT: begin
          byte_out_n   = rd_data;
          byte_valid_n = 1'b1;
          state_n      = PRESENT;
        end
        PRESENT: begin
          if (byte_ack) begin
            byte_valid_n = 1'b0;
            drained_n    = drained_count + 4'd1;
            if (idx == count - 4'd1) begin
              state_n = DONE;
            end else begin
              idx_n     = idx + 4'd1;
              rd_addr_n = idx + 4'd1;
              state_n   = ADDR;
            end
          end
        end
        DONE: begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_download_reader.sv
// tb/tb_camera_download_reader.sv - randomized self-checking bench for camera_download_reader
module tb_camera_download_reader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ready_to_download = 1'b0;
  logic [3:0] fill_level = '0;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ack = 1'b0;
  logic       busy, done, aborted;
  logic [3:0] drained_count;

  camera_download_reader #(.DEPTH(10), .DATA_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .ready_to_download(ready_to_download),
    .fill_level(fill_level), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack),
    .busy(busy), .done(done), .aborted(aborted), .drained_count(drained_count)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:15];
  always @(posedge clock) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // host model: 0 ack tied high, 1 random ack, 2 ack after 5 valid cycles
  int ack_mode = 0;
  int vcnt = 0;
  always @(posedge clock) begin
    #1;
    case (ack_mode)
      0: byte_ack = 1'b1;
      1: byte_ack = 1'($urandom_range(0, 1));
      default: begin
        vcnt = byte_valid ? vcnt + 1 : 0;
        byte_ack = (vcnt >= 5);
      end
    endcase
  end

  logic [7:0] acc_q[$];
  bit   mon_en = 0;
  int   done_cnt, ab_cnt, done_cyc, first_valid_cyc, valid_cyc;
  int   stab_err, drop_err, gap_err, inval_run, max_addr;
  bit   prev_valid, prev_ack, seen_byte;
  logic [7:0] prev_byte;

  always @(negedge clock) begin
    if (mon_en) begin
      if (byte_valid && byte_ack && ready_to_download) acc_q.push_back(byte_out);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) ab_cnt++;
      if (byte_valid) begin
        valid_cyc++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!prev_valid && seen_byte && inval_run < 2) gap_err++;
        seen_byte = 1;
        inval_run = 0;
      end else begin
        inval_run++;
      end
      if (prev_valid && !prev_ack && byte_valid && byte_out != prev_byte) stab_err++;
      if (prev_valid && !prev_ack && !byte_valid && !aborted) drop_err++;
      if (busy && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      prev_valid = byte_valid;
      prev_ack   = byte_ack;
      prev_byte  = byte_out;
    end
  end

  task automatic run_xfer(input string name, input int fill, input int mode, input int abort_at);
    int start_edge, n, n_exp;
    bit fin;
    fill_level = 4'(fill);
    ack_mode = mode;
    @(posedge clock); #1;
    ready_to_download = 1'b0;
    acc_q.delete();
    done_cnt = 0; ab_cnt = 0; done_cyc = -1; first_valid_cyc = -1; valid_cyc = 0;
    stab_err = 0; drop_err = 0; gap_err = 0; inval_run = 0; max_addr = 0;
    prev_valid = 0; prev_ack = 0; seen_byte = 0;
    mon_en = 1;
    @(posedge clock); #1;
    ready_to_download = 1'b1;
    start_edge = cyc + 1;
    fin = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      if (abort_at >= 0 && byte_valid && acc_q.size() == abort_at) ready_to_download = 1'b0;
      if (done_cnt > 0 || ab_cnt > 0) begin fin = 1; break; end
    end
    check({name, ":finished"}, 32'(fin), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    n = (fill > 10) ? 10 : fill;
    n_exp = (abort_at >= 0) ? abort_at : n;
    check({name, ":count"}, 32'(acc_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < acc_q.size(); i++)
      check($sformatf("%s:byte%0d", name, i), 32'(acc_q[i]), 32'(mem[i]));
    check({name, ":drained"}, 32'(drained_count), 32'(n_exp));
    check({name, ":done_pulses"}, 32'(done_cnt), (abort_at >= 0) ? 32'd0 : 32'd1);
    check({name, ":abort_pulses"}, 32'(ab_cnt), (abort_at >= 0) ? 32'd1 : 32'd0);
    check({name, ":busy_end"}, 32'(busy), 32'd0);
    check({name, ":stable"}, 32'(stab_err + drop_err), 32'd0);
    check({name, ":gap"}, 32'(gap_err), 32'd0);
    if (abort_at < 0) begin
      check({name, ":max_addr"}, 32'(max_addr), (n > 0) ? 32'(n - 1) : 32'd0);
      if (mode == 0 || n == 0) check({name, ":done_time"}, 32'(done_cyc - start_edge), 32'(3 * n + 1));
    end
    if (n > 0) check({name, ":first_valid"}, 32'(first_valid_cyc - start_edge), 32'd2);
    else check({name, ":no_valid"}, 32'(valid_cyc), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clock);
    #1;
    check("rst:busy", 32'(busy), 0);
    check("rst:valid", 32'(byte_valid), 0);
    check("rst:done", 32'(done), 0);
    check("rst:aborted", 32'(aborted), 0);
    check("rst:drained", 32'(drained_count), 0);
    check("rst:byte_out", 32'(byte_out), 0);
    check("rst:rd_addr", 32'(rd_addr), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    run_xfer("full", 10, 0, -1);
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    run_xfer("backpressure", 3, 2, -1);
    run_xfer("clamp", 15, 1, -1);
    run_xfer("zero", 0, 1, -1);
    run_xfer("abort", 6, 0, 2);

    // reset during WAIT, then hold ready high through release
    mon_en = 0;
    fill_level = 4'd6;
    ack_mode = 0;
    @(posedge clock); #1 ready_to_download = 1'b0;
    @(posedge clock); #1 ready_to_download = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midrst:in_wait", {30'd0, busy, byte_valid}, 32'b10);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midrst:busy", 32'(busy), 0);
    check("midrst:valid", 32'(byte_valid), 0);
    check("midrst:byte_out", 32'(byte_out), 0);
    check("midrst:rd_addr", 32'(rd_addr), 0);
    check("midrst:drained", 32'(drained_count), 0);
    check("midrst:pulses", {30'd0, done, aborted}, 0);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("edge_rule:no_start", {30'd0, busy, byte_valid}, 0);
    run_xfer("after_reset", 6, 1, -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_xfer($sformatf("rand%0d", t), $urandom_range(0, 15), $urandom_range(0, 2), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
